sr_trace_buffer: RTL
====================

# sr_trace_buffer

On-chip instruction trace buffer with watchdog, the synthesizable successor to the simulation-only cycle trace and timeout used around `sr_cpu`. It records the PC and instruction word of every retired instruction into a circular buffer of `DEPTH` entries. Capture freezes on a PC-match trigger plus post-trigger window, on buffer full in stop mode, or on a cycle-count timeout. A debug host can then read entries back, oldest first, while the CPU runs or halts.

## Interface
- `DEPTH`, 16: entries; power of two, ≥2; `AW = log2(DEPTH)`
- `TIMEOUT`, 120: watchdog limit in capture cycles; 0 disables watchdog
- `POST_TRIG`, 4: entries captured after the trigger entry; range 0..DEPTH-1

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous clear/re-arm
- `valid`  in  1  instruction retired this cycle
- `pc`  in  32  retired instruction PC
- `instr`  in  32  retired instruction word
- `mode`  in  1  0 = wrap (overwrite oldest), 1 = stop when full
- `trig_en`  in  1  enable PC-match trigger
- `trig_pc`  in  32  trigger PC
- `rd_idx`  in  AW  read index, 0 = oldest valid entry
- `rd_pc`  out  32  PC of entry `rd_idx`, registered
- `rd_instr`  out  32  instruction word of entry `rd_idx`, registered
- `count`  out  AW+1  valid entries, saturates at DEPTH
- `frozen`  out  1  capture stopped
- `triggered`  out  1  trigger has fired (sticky)
- `timeout`  out  1  watchdog expired (sticky)
- `cycle`  out  32  capture-cycle counter

## Operation
- States: CAPTURE, POST, FROZEN. Reset and `clr` enter CAPTURE.
- **Reset values:**
  - All outputs are 0, `wr_ptr`=0, `post_cnt`=0.
  - Buffer RAM contents are don't-care.
- **Buffer write:** occurs in CAPTURE or POST when `valid`=1.
  - `mem[wr_ptr] <= {pc, instr}`.
  - `wr_ptr` increments modulo DEPTH.
  - `count` increments, saturating at DEPTH.
- **CAPTURE:**
  - If `valid`, `trig_en`, and `pc==trig_pc`:
    - The entry is written.
    - `triggered` <= 1.
    - If `POST_TRIG`=0, go to FROZEN. Otherwise load `post_cnt`=`POST_TRIG` and go to POST.
  - The trigger is armed only in CAPTURE. A match in POST or FROZEN is ignored.
- **POST:** each write decrements `post_cnt`. A write with `post_cnt`=1 goes to FROZEN.
- **Stop mode:**
  - In `mode`=1, a write that makes `count`=DEPTH goes to FROZEN, in either CAPTURE or POST.
  - In `mode`=0, the buffer wraps and the oldest entry is overwritten.
  - `mode` is sampled every cycle. The team does not change it mid-capture.
- **FROZEN:**
  - `valid` is ignored.
  - The buffer, `count` and `cycle` hold.
  - `frozen`=1 whenever the state is FROZEN.
- **Watchdog:**
  - `cycle` increments every clock in CAPTURE/POST, regardless of `valid`, and saturates at 2^32-1.
  - If `TIMEOUT`≠0 and the incremented value equals `TIMEOUT`, then `timeout` <= 1 and the state goes to FROZEN.
  - A write in that same cycle still occurs.
- **Simultaneous freeze causes:** all sticky flags that apply in the cycle are set.
- **`clr`:**
  - Takes priority over everything; a sample presented with `clr` is discarded.
  - Zeroes `count`, `wr_ptr`, `cycle`, `triggered`, `timeout`, `post_cnt`, and enters CAPTURE.
  - Buffer contents are not erased.
- **Readout:**
  - Physical address = `oldest + rd_idx` mod DEPTH.
  - `oldest` = `wr_ptr` when `count`==DEPTH, else 0.
  - If `rd_idx >= count`, `rd_pc`/`rd_instr` register to 0.
  - Readout works in any state. If a read hits the entry being written in the same cycle, it returns the old contents (read-before-write).

## Timing
- Write latency: the sample at edge N is visible via readout from edge N+1; the requested data is registered at edge N+2.
- Read latency: 1 cycle, from `rd_idx` to `rd_pc`/`rd_instr`.
- `count`, `frozen`, `triggered`, `timeout` and `cycle` are registered and update on the edge that performs the causing write or tick.
- `rst_n` assertion mid-capture clears state immediately, asynchronously. Release is synchronized externally to `clk`.

## Test plan
- **Wrap:** DEPTH=16, `mode`=0, 20 writes with pc=4·k.
  - `count`=16, `frozen`=0.
  - rd_idx 0 returns pc=0x10; rd_idx 15 returns pc=0x4C.
- **Stop:** `mode`=1, 20 writes.
  - `frozen`=1 on the edge of write 16, `count`=16.
  - rd_idx 15 returns pc=0x3C; writes 17-20 are absent.
- **Trigger:** `trig_pc`=0x20, POST_TRIG=4, continuous pc=4·k.
  - `triggered`=1 at pc 0x20.
  - Frozen after pc 0x30; newest entry 0x30, `count`=13.
  - A second pass of 0x20 is ignored.
- **Timeout:** TIMEOUT=120, `valid`=0 throughout.
  - `cycle`=120, `timeout`=1, `frozen`=1 on the same edge.
  - `cycle` holds at 120.
- **Clear/reset:**
  - `clr` together with a matching `valid` leaves `count`=0 and `triggered`=0, state CAPTURE.
  - Asserting `rst_n`=0 mid-POST zeroes all outputs asynchronously.
- **Empty read:** after `clr`, rd_idx 3 returns 0 on both read ports.

Source files
------------

// File: rtl/sr_trace_buffer_if.sv
// Bundles the control, capture and readout signals of the trace buffer.
interface sr_trace_buffer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          clr;
  logic          valid;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          mode;
  logic          trig_en;
  logic [31:0]   trig_pc;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_instr;
  logic [AW:0]   count;
  logic          frozen;
  logic          triggered;
  logic          timeout;
  logic [31:0]   cycle;

  modport master (
    output clr, valid, pc, instr, mode, trig_en, trig_pc, rd_idx,
    input  rd_pc, rd_instr, count, frozen, triggered, timeout, cycle
  );

  modport slave (
    input  clr, valid, pc, instr, mode, trig_en, trig_pc, rd_idx,
    output rd_pc, rd_instr, count, frozen, triggered, timeout, cycle
  );
endinterface

// File: rtl/sr_trace_buffer.sv
// Instruction trace buffer: circular capture of retired {pc, instr} pairs with
// PC trigger + post-trigger window, stop-when-full mode and cycle watchdog.
module sr_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TIMEOUT   = 120,
  parameter int unsigned POST_TRIG = 4
) (
  input logic              clk,
  input logic              rst_n,
  sr_trace_buffer_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PT = AW'(POST_TRIG);

  typedef enum logic [1:0] {S_CAPTURE, S_POST, S_FROZEN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          triggered_q, triggered_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   rd_pc_q, rd_instr_q;
  logic [63:0]   mem [DEPTH];

  logic          we;
  logic          trig_hit;
  logic          freeze;
  logic [AW:0]   count_inc;
  logic [31:0]   cycle_inc;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;

  assign we        = bus.valid && !bus.clr && (state_q != S_FROZEN);
  assign trig_hit  = bus.valid && bus.trig_en && (bus.pc == bus.trig_pc);
  assign count_inc = (count_q == FULL) ? count_q : count_q + 1'b1;
  assign cycle_inc = (&cycle_q) ? cycle_q : cycle_q + 32'd1;

  // Once the buffer has wrapped the oldest entry sits at the write pointer.
  assign rd_addr = ((count_q == FULL) ? wr_ptr_q : '0) + bus.rd_idx;
  assign rd_hit  = ({1'b0, bus.rd_idx} < count_q);

  // Next-state: clear dominates; all freeze causes may coincide and each sets its flag.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    post_cnt_d  = post_cnt_q;
    count_d     = count_q;
    cycle_d     = cycle_q;
    triggered_d = triggered_q;
    timeout_d   = timeout_q;
    freeze      = 1'b0;
    if (bus.clr) begin
      state_d     = S_CAPTURE;
      wr_ptr_d    = '0;
      post_cnt_d  = '0;
      count_d     = '0;
      cycle_d     = '0;
      triggered_d = 1'b0;
      timeout_d   = 1'b0;
    end else if (state_q != S_FROZEN) begin
      cycle_d = cycle_inc;
      if (bus.valid) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_inc;
      end
      if (state_q == S_CAPTURE && trig_hit) begin
        triggered_d = 1'b1;
        if (POST_TRIG == 0) begin
          freeze = 1'b1;
        end else begin
          post_cnt_d = PT;
          state_d    = S_POST;
        end
      end
      if (state_q == S_POST && bus.valid) begin
        post_cnt_d = post_cnt_q - 1'b1;
        if (post_cnt_q == AW'(1)) freeze = 1'b1;
      end
      if (bus.mode && bus.valid && count_inc == FULL) freeze = 1'b1;
      if (TIMEOUT != 0 && cycle_inc == 32'(TIMEOUT)) begin
        timeout_d = 1'b1;
        freeze    = 1'b1;
      end
      if (freeze) state_d = S_FROZEN;
    end
  end

  // Control state and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CAPTURE;
      wr_ptr_q    <= '0;
      post_cnt_q  <= '0;
      count_q     <= '0;
      cycle_q     <= '0;
      triggered_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      post_cnt_q  <= post_cnt_d;
      count_q     <= count_d;
      cycle_q     <= cycle_d;
      triggered_q <= triggered_d;
      timeout_q   <= timeout_d;
    end
  end

  // Trace RAM write; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= {bus.pc, bus.instr};
  end

  // Registered readout; reads the pre-write contents on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
    end else if (rd_hit) begin
      {rd_pc_q, rd_instr_q} <= mem[rd_addr];
    end else begin
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
    end
  end

  assign bus.rd_pc     = rd_pc_q;
  assign bus.rd_instr  = rd_instr_q;
  assign bus.count     = count_q;
  assign bus.frozen    = (state_q == S_FROZEN);
  assign bus.triggered = triggered_q;
  assign bus.timeout   = timeout_q;
  assign bus.cycle     = cycle_q;
endmodule
